// File: rtl/rgb_unpack_pkg.sv
// Shared types and constants for the 32-bit word to 24-bit RGB pixel unpacker.
package rgb_unpack_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [23:0] pixel_t;
    typedef logic [31:0] word_t;

    // State value equals the number of bytes held in the residue register.
    // PAD is only reachable when RGB_UNPACK_PAD_EN is defined.
    typedef enum logic [2:0] {
        P0  = 3'd0,
        P1  = 3'd1,
        P2  = 3'd2,
        P3  = 3'd3,
        PAD = 3'd4
    } state_e;

    // Three input words carry exactly this many pixels.
    localparam int unsigned PIXELS_PER_GROUP = 4;

    // States in which a new input word may be consumed.
    function automatic logic takes_input(state_e s);
        return (s == P0) || (s == P1) || (s == P2);
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-deep AXI-Stream output register; loads when empty or when the held beat leaves.
module axis_out_reg #(
    parameter int unsigned Width = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_data,
    input  logic             load_last,
    input  logic             ready,
    output logic             valid,
    output logic [Width-1:0] data,
    output logic             last,
    output logic             load_ok
);

    // The register may take a new beat whenever nothing is held or the held beat is leaving.
    always_comb begin
        load_ok = !valid || ready;
    end

    // Hold data/last stable under backpressure; drop valid once the beat is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rgb_word_unpack.sv
// Unpacks a byte stream of 32-bit AXI-Stream words into 24-bit RGB pixels (3 words -> 4 pixels).
// Optional feature: define RGB_UNPACK_PAD_EN to emit a zero-padded pixel for 1 or 2 leftover
// bytes at frame end instead of dropping them.
module rgb_word_unpack
    import rgb_unpack_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_M_AXIS_TDATA_WIDTH = 24
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_areset,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                              s00_axis_tlast,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                              m00_axis_tlast,
    output logic                              m00_axis_tvalid,
    input  logic                              m00_axis_tready,
    output logic                              frag_err
);

    // Only the 32-in / 24-out geometry is implemented.
    if (C_S_AXIS_TDATA_WIDTH != 32 || C_M_AXIS_TDATA_WIDTH != 24 ||
        3 * C_S_AXIS_TDATA_WIDTH != PIXELS_PER_GROUP * C_M_AXIS_TDATA_WIDTH) begin : g_bad_width
        $error("rgb_word_unpack supports only 32-bit input and 24-bit output");
    end

    state_e state_q, state_d;
    pixel_t residue_q, residue_d;
    logic   last_pend_q, last_pend_d;
    logic   frag_q, frag_d;

    logic   load, load_last, load_ok, accept;
    pixel_t load_data;
    word_t  word;

    // tstrb carries no information here; every byte is valid.
    logic unused_tstrb;
    assign unused_tstrb = ^s00_axis_tstrb;

    assign word            = s00_axis_tdata;
    assign m00_axis_tstrb  = 3'b111;
    assign frag_err        = frag_q;
    assign s00_axis_tready = load_ok && !s00_axis_areset && takes_input(state_q);
    assign accept          = s00_axis_tvalid && s00_axis_tready;

    // Next-state, residue and output-load decode for the byte-phase FSM.
    always_comb begin
        state_d     = state_q;
        residue_d   = residue_q;
        last_pend_d = last_pend_q;
        frag_d      = frag_q;
        load        = 1'b0;
        load_data   = '0;
        load_last   = 1'b0;
        case (state_q)
            P0: begin
                if (accept) begin
                    load      = 1'b1;
                    load_data = word[23:0];
                    residue_d = {16'h0, word[31:24]};
                    state_d   = P1;
                    if (s00_axis_tlast) begin
                        frag_d = 1'b1;
`ifdef RGB_UNPACK_PAD_EN
                        state_d = PAD;
`else
                        load_last = 1'b1;
                        residue_d = '0;
                        state_d   = P0;
`endif
                    end
                end
            end
            P1: begin
                if (accept) begin
                    load      = 1'b1;
                    load_data = {word[15:0], residue_q[7:0]};
                    residue_d = {8'h0, word[31:16]};
                    state_d   = P2;
                    if (s00_axis_tlast) begin
                        frag_d = 1'b1;
`ifdef RGB_UNPACK_PAD_EN
                        state_d = PAD;
`else
                        load_last = 1'b1;
                        residue_d = '0;
                        state_d   = P0;
`endif
                    end
                end
            end
            P2: begin
                if (accept) begin
                    load        = 1'b1;
                    load_data   = {word[7:0], residue_q[15:0]};
                    residue_d   = word[31:8];
                    last_pend_d = s00_axis_tlast;
                    state_d     = P3;
                end
            end
            P3: begin
                if (load_ok) begin
                    load        = 1'b1;
                    load_data   = residue_q;
                    load_last   = last_pend_q;
                    residue_d   = '0;
                    last_pend_d = 1'b0;
                    state_d     = P0;
                end
            end
`ifdef RGB_UNPACK_PAD_EN
            PAD: begin
                // Residue upper bytes are already zero, so it doubles as the padded pixel.
                if (load_ok) begin
                    load      = 1'b1;
                    load_data = residue_q;
                    load_last = 1'b1;
                    residue_d = '0;
                    state_d   = P0;
                end
            end
`endif
            default: begin
                state_d     = P0;
                residue_d   = '0;
                last_pend_d = 1'b0;
            end
        endcase
    end

    // FSM, residue and sticky fragment flag registers.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state_q     <= P0;
            residue_q   <= '0;
            last_pend_q <= 1'b0;
            frag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            residue_q   <= residue_d;
            last_pend_q <= last_pend_d;
            frag_q      <= frag_d;
        end
    end

    axis_out_reg #(
        .Width(24)
    ) u_out (
        .clk       (s00_axis_aclk),
        .rst       (s00_axis_areset),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .ready     (m00_axis_tready),
        .valid     (m00_axis_tvalid),
        .data      (m00_axis_tdata),
        .last      (m00_axis_tlast),
        .load_ok   (load_ok)
    );

endmodule

// File: tb/tb_rgb_word_unpack.sv
// Self-checking bench for rgb_word_unpack: byte-queue reference model plus literal expectations.
module tb_rgb_word_unpack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = 4'hf;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [23:0] m_tdata;
    logic [2:0]  m_tstrb;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        frag_err;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0]  byte_q[$];
    logic [24:0] exp_q[$];   // {last, pixel}
    logic        exp_frag = 1'b0;
    logic [24:0] log_q[$];   // pixels actually transferred
    logic        tog = 1'b0;

    rgb_word_unpack dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tstrb  (s_tstrb),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tready (s_tready),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tstrb  (m_tstrb),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tready (m_tready),
        .frag_err        (frag_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: bytes in stream order, grouped three at a time into pixels.
    task automatic model_word(input logic [31:0] w, input logic last);
        logic [24:0] p;
        logic [31:0] wv;
        wv = w;
        for (int k = 0; k < 4; k++) byte_q.push_back(wv[8*k +: 8]);
        while (byte_q.size() >= 3) begin
            p = {1'b0, byte_q[2], byte_q[1], byte_q[0]};
            exp_q.push_back(p);
            for (int k = 0; k < 3; k++) void'(byte_q.pop_front());
        end
        if (last) begin
            if (byte_q.size() != 0) begin
                exp_frag = 1'b1;
`ifdef RGB_UNPACK_PAD_EN
                if (byte_q.size() == 1) p = {1'b1, 16'h0, byte_q[0]};
                else                    p = {1'b1, 8'h0, byte_q[1], byte_q[0]};
                exp_q.push_back(p);
`else
                p = exp_q[exp_q.size()-1];
                p[24] = 1'b1;
                exp_q[exp_q.size()-1] = p;
`endif
                byte_q.delete();
            end else begin
                p = exp_q[exp_q.size()-1];
                p[24] = 1'b1;
                exp_q[exp_q.size()-1] = p;
            end
        end
    endtask

    // Compare process: every cycle check frag_err and any valid pixel against the model head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                byte_q.delete();
                exp_q.delete();
                exp_frag = 1'b0;
            end else begin
                check("frag_err", {31'b0, frag_err}, {31'b0, exp_frag});
                if (m_tvalid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pixel", {7'b0, m_tlast, m_tdata}, 32'hffff_ffff);
                    end else begin
                        check("pixel", {7'b0, m_tlast, m_tdata}, {7'b0, exp_q[0]});
                        if (m_tready) begin
                            log_q.push_back({m_tlast, m_tdata});
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (s_tvalid && s_tready) model_word(s_tdata, s_tlast);
            end
        end
    end

    // Optional downstream backpressure: toggle ready every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog) m_tready = ~m_tready;
        end
    end

    task automatic send(input logic [31:0] w, input logic last);
        int n;
        n = 0;
        s_tvalid = 1'b1;
        s_tdata  = w;
        s_tlast  = last;
        @(negedge clk);
        while (!s_tready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!s_tready) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(posedge clk);
        #2;
        while ((exp_q.size() != 0 || m_tvalid) && n < 100) begin
            n++;
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0 || m_tvalid) check("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string name, input logic [24:0] lit[$]);
        check({name, "_count"}, log_q.size(), lit.size());
        for (int i = 0; i < lit.size() && i < log_q.size(); i++)
            check(name, {7'b0, log_q[i]}, {7'b0, lit[i]});
        log_q.delete();
    endtask

    initial begin
        logic [24:0] lit[$];
        int lows;
        logic [31:0] w;

        // Reset state, with tvalid asserted to prove tready is forced low.
        s_tvalid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tready", {31'b0, s_tready}, 32'd0);
        check("rst_tvalid", {31'b0, m_tvalid}, 32'd0);
        check("rst_tdata", {8'b0, m_tdata}, 32'd0);
        check("rst_tlast", {31'b0, m_tlast}, 32'd0);
        check("rst_frag", {31'b0, frag_err}, 32'd0);
        check("tstrb", {29'b0, m_tstrb}, 32'd7);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic group of three words, ready always high.
        send(32'h44332211, 1'b0);
        send(32'h88776655, 1'b0);
        send(32'hCCBBAA99, 1'b1);
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!s_tready) lows++;
        end
        check("stall_cycles", lows, 32'd1);
        drain();
        lit = '{25'h0332211, 25'h0665544, 25'h0998877, 25'h1CCBBAA};
        check_log("t1", lit);

        // Same stream with toggling backpressure.
        tog = 1'b1;
        send(32'h44332211, 1'b0);
        send(32'h88776655, 1'b0);
        send(32'hCCBBAA99, 1'b1);
        drain();
        tog = 1'b0;
        m_tready = 1'b1;
        check_log("t2", lit);

        // Two back-to-back 6-word frames; bytes count 0,1,2,...
        for (int i = 0; i < 12; i++) begin
            w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            send(w, (i == 5) || (i == 11));
        end
        drain();
        lit.delete();
        for (int j = 0; j < 16; j++)
            lit.push_back({(j == 7) || (j == 15), 8'(3*(j%8)+2+24*(j/8)),
                           8'(3*(j%8)+1+24*(j/8)), 8'(3*(j%8)+24*(j/8))});
        check_log("t6", lit);
        check("t6_frag", {31'b0, frag_err}, 32'd0);

        // Single fragmented word.
        send(32'h44332211, 1'b1);
        drain();
`ifdef RGB_UNPACK_PAD_EN
        lit = '{25'h0332211, 25'h1000044};
`else
        lit = '{25'h1332211};
`endif
        check_log("t3", lit);
        check("t3_frag", {31'b0, frag_err}, 32'd1);

        // Two words then realignment with a new frame.
        send(32'h44332211, 1'b0);
        send(32'h88776655, 1'b1);
        send(32'h03020100, 1'b1);
        drain();
`ifdef RGB_UNPACK_PAD_EN
        lit = '{25'h0332211, 25'h0665544, 25'h1008877, 25'h0020100, 25'h1000003};
`else
        lit = '{25'h0332211, 25'h1665544, 25'h1020100};
`endif
        check_log("t4", lit);

        // Reset mid-frame with a pixel pending under backpressure.
        m_tready = 1'b0;
        send(32'h44332211, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tvalid", {31'b0, m_tvalid}, 32'd0);
        check("mid_rst_tdata", {8'b0, m_tdata}, 32'd0);
        check("mid_rst_tlast", {31'b0, m_tlast}, 32'd0);
        check("mid_rst_frag", {31'b0, frag_err}, 32'd0);
        check("mid_rst_tready", {31'b0, s_tready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_tready = 1'b1;
        log_q.delete();
        send(32'h44332211, 1'b1);
        drain();
`ifdef RGB_UNPACK_PAD_EN
        lit = '{25'h0332211, 25'h1000044};
`else
        lit = '{25'h1332211};
`endif
        check_log("t5", lit);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
